// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 1250;  // 12 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line towards the receiver plus received byte and status strobes.
// Defining UART_RX_PARITY_EN adds the parity_err strobe.
interface uart_rx_sampler_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output rx, input rx_data, rx_valid, frame_err, busy, parity_err);
  modport slave  (input rx, output rx_data, rx_valid, frame_err, busy, parity_err);
`else
  modport master (output rx, input rx_data, rx_valid, frame_err, busy);
  modport slave  (input rx, output rx_data, rx_valid, frame_err, busy);
`endif

endinterface

// File: rtl/sync_ff.sv
// sync_ff: N-stage synchronizer for an asynchronous level input; every stage resets to 1
// so an idle-high line or a released push-button never produces a spurious edge.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_reg;

  // Shift the raw input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '1;
    else     sync_reg <= {sync_reg[N-2:0], d};
  end

  assign q = sync_reg[N-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver, LSB first, idle-high line, mid-bit sampling.
// Optional even parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input logic              hwclk,
  input logic              rst,
  uart_rx_sampler_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Start bit is checked half a bit in; later bits a full bit after the previous sample.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  logic                 rx_prev_reg;
  uart_state_e          state_reg, state_next;
  logic [CNT_W-1:0]     clk_cnt_reg;
  logic [2:0]           bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg, frame_err_reg, busy_reg;

  logic start_tick, bit_tick, cnt_clr, shift_en, stop_good, stop_bad, frame_ok;

  sync_ff #(.N(SYNC_STAGES)) u_sync (
    .clk (hwclk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // State register.
  always_ff @(posedge hwclk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: edge detect, start-bit confirm, data/parity/stop bit walk.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (rx_prev_reg && !rx_s) state_next = START;
      START:  if (start_tick) state_next = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_tick && bit_idx_reg == 3'd7) state_next = PARITY;
`else
      DATA:   if (bit_tick && bit_idx_reg == 3'd7) state_next = STOP;
`endif
      PARITY: if (bit_tick) state_next = STOP;
      STOP:   if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: sample points and the enables they produce.
  always_comb begin
    start_tick = (state_reg == START) && (clk_cnt_reg == HALF_LAST);
    bit_tick   = (state_reg inside {DATA, PARITY, STOP}) && (clk_cnt_reg == BIT_LAST);
    cnt_clr    = (state_reg == IDLE) || start_tick || bit_tick;
    shift_en   = (state_reg == DATA) && bit_tick;
    stop_good  = (state_reg == STOP) && bit_tick && rx_s;
    stop_bad   = (state_reg == STOP) && bit_tick && !rx_s;
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bit_reg, parity_err_reg, parity_bad;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = ^{shift_reg, parity_bit_reg};
  assign frame_ok   = stop_good && !parity_bad;

  // Capture the parity bit and raise parity_err only when the stop bit is good.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      if (state_reg == PARITY && bit_tick) parity_bit_reg <= rx_s;
      parity_err_reg <= stop_good && parity_bad;
    end
  end

  assign bus.parity_err = parity_err_reg;
`else
  assign frame_ok = stop_good;
`endif

  // Bit timing counter, bit index, and LSB-first shift register.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      rx_prev_reg <= 1'b1;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      rx_prev_reg <= rx_s;
      clk_cnt_reg <= cnt_clr ? '0 : clk_cnt_reg + 1'b1;
      if (start_tick)    bit_idx_reg <= '0;
      else if (shift_en) bit_idx_reg <= bit_idx_reg + 3'd1;
      if (shift_en)      shift_reg   <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  // Registered outputs: one-cycle strobes, held byte, busy.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      rx_valid_reg  <= frame_ok;
      frame_err_reg <= stop_bad;
      busy_reg      <= (state_reg != IDLE);
      if (frame_ok) rx_data_reg <= shift_reg;
    end
  end

  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Serial UART receiver that consumes the line driven by the shift-register UART transmitter (ftdi_tx side) and turns it back into bytes.
- Used in loopback tests on the iCE40 board, and on the FTDI RX pin for host-to-board traffic.
- Receives 8N1 frames, LSB first, idle-high line, with mid-bit sampling derived from a clock-cycle bit counter.
- Produces a one-cycle valid strobe per received byte and flags framing errors.

Parameters:
- CLKS_PER_BIT, 1250: hwclk cycles per bit (12 MHz / 9600). Must be >= 4.
- SYNC_STAGES, 2: input synchronizer depth. Must be >= 2.

Ports:
- hwclk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last correctly framed byte; held until the next valid frame.
- rx_valid  output  1  one-cycle strobe; rx_data is new in that same cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high from start-bit detection until the frame ends (valid or error strobe cycle inclusive).

Behaviour:
- Reset (rst high at a clock edge):
  - rx_data = 0x00; rx_valid, frame_err and busy = 0.
  - Synchronizer flops and the previous-sample register = 1; state = IDLE; counters = 0.
  - Reset mid-frame aborts the frame with no strobe.
- Synchronizer: rx passes through SYNC_STAGES flops. The synchronized value is rx_s; all decisions use rx_s.
- Counter: clk_cnt is sized $clog2(CLKS_PER_BIT). bit_idx is 3 bits.
- FSM states and transitions:
  - IDLE: on a falling edge of rx_s (previous 1, current 0), go to START and clear clk_cnt. A line held low never retriggers.
  - START: at clk_cnt == CLKS_PER_BIT/2 - 1, sample rx_s.
    - If 0: go to DATA, clear clk_cnt and bit_idx.
    - If 1: glitch. Return to IDLE with no strobe.
  - DATA: at clk_cnt == CLKS_PER_BIT - 1, shift rx_s into the MSB of the shift register (LSB-first line order) and clear clk_cnt. After bit_idx == 7 is sampled, go to STOP (or PARITY when enabled).
  - STOP: at clk_cnt == CLKS_PER_BIT - 1, sample rx_s.
    - If 1: load rx_data from the shift register and pulse rx_valid.
    - If 0: pulse frame_err and leave rx_data unchanged.
    - Either way, go to IDLE.
- Timing:
  - The strobe fires in the cycle after the stop-bit sample edge.
  - A new start bit is accepted from the first IDLE cycle. Back-to-back frames with no idle gap are received.
- Latency: falling edge on rx to rx_valid = SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1.
- busy = (state != IDLE), registered.
- rx_valid and frame_err are never high in the same cycle.
- Strobes are never stretched. Downstream logic must capture on the strobe; there is no backpressure.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit at mid-bit.
  - Adds output parity_err (1 bit, resets to 0). It strobes in place of rx_valid when the XOR of the 8 data bits and the parity bit is 1; rx_data is then not updated.
  - If the stop bit is also bad, frame_err takes priority and parity_err stays low.
- Undefined: 8N1 only; no parity_err port.

Decomposition:
- Package uart_pkg holds:
  - The state enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS = 8.
  - The default CLKS_PER_BIT.
  - Shared with the transmitter.
- One natural sub-module: sync_ff (parameterised depth N, reset value 1), reused for the push-button input.

Test Plan (CLKS_PER_BIT = 8, SYNC_STAGES = 2):
- Send 0xA5 as 8N1 -> exactly one rx_valid with rx_data = 0xA5; frame_err stays 0; busy falls the cycle after the strobe.
- Drive rx low for 2 cycles, then high -> no strobe; busy rises, then returns to 0 after the START check.
- Send 0x3C with the stop bit forced to 0 -> frame_err strobes once; rx_data keeps its previous value; line held low afterwards causes no retrigger.
- Send 0x00, 0xFF, 0x55 back-to-back with no idle bits -> three rx_valid strobes carrying those values in order.
- Assert rst mid-way through bit 4 of 0x81 -> outputs return to reset values; no strobe; the next frame 0x42 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> rx_valid, rx_data = 0x07. Send 0x07 with parity bit 0 -> parity_err strobe; rx_data unchanged.
